// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-flags, sticky error flags and flush.
// Holds exactly DEPTH entries; pointers wrap explicitly so non-power-of-two depths work.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             flush,
  input  logic             err_clr,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic wr_acc, rd_acc, wr_rej, rd_rej;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Status is decoded from the registered count only.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));

  // Flush swallows same-cycle requests, so they are neither accepted nor flagged.
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_rej = wr_en & full & ~flush;
  assign rd_rej = rd_en & empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    // A new error in the same cycle as err_clr keeps the flag set.
    overflow_d  = wr_rej | (overflow_q & ~err_clr);
    underflow_d = rd_rej | (underflow_q & ~err_clr);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_acc) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (reset && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1).
// Table rows give inputs for one edge and the outputs expected just after it.
module tb_sync_fifo_param;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 5;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(
    .WIDTH   (W),
    .DEPTH   (D),
    .AF_LEVEL(4),
    .AE_LEVEL(1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .flush       (flush),
    .err_clr     (err_clr),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       fl;
    logic       ec;
    int         cnt;
    logic       rv;
    logic [7:0] rdat;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic wr, input logic [7:0] wd, input logic rd,
                     input logic fl, input logic ec, input int cnt, input logic rv,
                     input logic [7:0] rdat, input logic ovf, input logic unf);
    vec_t v;
    v = '{rst_n, wr, wd, rd, fl, ec, cnt, rv, rdat, ovf, unf};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic wr, input logic [7:0] wd, input logic rd,
                      input logic fl, input logic ec);
    reset   = rst_n;
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    flush   = fl;
    err_clr = ec;
    @(posedge clock);
    #1;
  endtask

  // Flags are decoded from the expected count using the DEPTH=5 / AF=4 / AE=1 thresholds.
  task automatic chk_status(input string tag, input int cnt);
    chk({tag, " count"}, 8'(count), 8'(cnt));
    chk({tag, " empty"}, 8'(empty), 8'(cnt == 0));
    chk({tag, " full"}, 8'(full), 8'(cnt == 5));
    chk({tag, " almost_empty"}, 8'(almost_empty), 8'(cnt <= 1));
    chk({tag, " almost_full"}, 8'(almost_full), 8'(cnt >= 4));
  endtask

  initial begin
    // 1: reset held with wr_en active
    add(0, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // 2: fill A1..A5, drain in order
    add(1, 1, 8'hA1, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 1, 8'hA2, 0, 0, 0, 2, 0, 8'h00, 0, 0);
    add(1, 1, 8'hA3, 0, 0, 0, 3, 0, 8'h00, 0, 0);
    add(1, 1, 8'hA4, 0, 0, 0, 4, 0, 8'h00, 0, 0);
    add(1, 1, 8'hA5, 0, 0, 0, 5, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 4, 1, 8'hA1, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 3, 1, 8'hA2, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 2, 1, 8'hA3, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 8'hA4, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0, 1, 8'hA5, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 0, 0);
    // 4: overflow on full, contents intact, underflow on empty, set beats clear
    add(1, 1, 8'hB1, 0, 0, 0, 1, 0, 8'hA5, 0, 0);
    add(1, 1, 8'hB2, 0, 0, 0, 2, 0, 8'hA5, 0, 0);
    add(1, 1, 8'hB3, 0, 0, 0, 3, 0, 8'hA5, 0, 0);
    add(1, 1, 8'hB4, 0, 0, 0, 4, 0, 8'hA5, 0, 0);
    add(1, 1, 8'hB5, 0, 0, 0, 5, 0, 8'hA5, 0, 0);
    add(1, 1, 8'hEE, 0, 0, 0, 5, 0, 8'hA5, 1, 0);
    add(1, 0, 8'h00, 0, 0, 1, 5, 0, 8'hA5, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 4, 1, 8'hB1, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 3, 1, 8'hB2, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 2, 1, 8'hB3, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 8'hB4, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0, 1, 8'hB5, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0, 0, 8'hB5, 0, 1);
    add(1, 0, 8'h00, 1, 0, 1, 0, 0, 8'hB5, 0, 1);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'hB5, 0, 0);
    // 5: simultaneous access at count 1, then at full
    add(1, 1, 8'h11, 0, 0, 0, 1, 0, 8'hB5, 0, 0);
    add(1, 1, 8'h22, 1, 0, 0, 1, 1, 8'h11, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h22, 0, 0);
    add(1, 1, 8'hC1, 0, 0, 0, 1, 0, 8'h22, 0, 0);
    add(1, 1, 8'hC2, 0, 0, 0, 2, 0, 8'h22, 0, 0);
    add(1, 1, 8'hC3, 0, 0, 0, 3, 0, 8'h22, 0, 0);
    add(1, 1, 8'hC4, 0, 0, 0, 4, 0, 8'h22, 0, 0);
    add(1, 1, 8'hC5, 0, 0, 0, 5, 0, 8'h22, 0, 0);
    add(1, 1, 8'hDD, 1, 0, 0, 4, 1, 8'hC1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 1, 4, 0, 8'hC1, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 3, 1, 8'hC2, 0, 0);
    // 6: flush mid-stream ignores wr/rd, then reset mid-stream with a read in flight
    add(1, 1, 8'h77, 1, 1, 0, 0, 0, 8'hC2, 0, 0);
    add(1, 1, 8'h33, 0, 0, 0, 1, 0, 8'hC2, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h33, 0, 0);
    add(1, 1, 8'h44, 0, 0, 0, 1, 0, 8'h33, 0, 0);
    add(1, 1, 8'h55, 0, 0, 0, 2, 0, 8'h33, 0, 0);
    add(1, 1, 8'h66, 0, 0, 0, 3, 0, 8'h33, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 2, 1, 8'h44, 0, 0);
    add(0, 1, 8'h99, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    add(1, 1, 8'h33, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h33, 0, 0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].rst_n, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].fl, vecs[i].ec);
      chk_status(tag, vecs[i].cnt);
      chk({tag, " rd_valid"}, 8'(rd_valid), 8'(vecs[i].rv));
      chk({tag, " rd_data"}, rd_data, vecs[i].rdat);
      chk({tag, " overflow"}, 8'(overflow), 8'(vecs[i].ovf));
      chk({tag, " underflow"}, 8'(underflow), 8'(vecs[i].unf));
    end

    // 3: write 3 / read 3 for 4 rounds; pointers start at 1 and cross 4->0 in round 2
    for (int r = 1; r <= 4; r++) begin
      for (int i = 1; i <= 3; i++) begin
        step(1, 1, 8'(r * 16 + i), 0, 0, 0);
        chk_status($sformatf("wrap r%0d w%0d", r, i), i);
      end
      for (int i = 1; i <= 3; i++) begin
        step(1, 0, 8'h00, 1, 0, 0);
        chk($sformatf("wrap r%0d rv%0d", r, i), 8'(rd_valid), 8'h01);
        chk($sformatf("wrap r%0d rd%0d", r, i), rd_data, 8'(r * 16 + i));
        chk_status($sformatf("wrap r%0d c%0d", r, i), 3 - i);
      end
      step(1, 0, 8'h00, 0, 0, 0);
      chk($sformatf("wrap r%0d idle rv", r), 8'(rd_valid), 8'h00);
    end

    // Sticky overflow survives a flush, then reset clears it.
    for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h50 + i), 0, 0, 0);
    chk("ovf after fill", 8'(overflow), 8'h01);
    step(1, 0, 8'h00, 0, 1, 0);
    chk("ovf kept by flush", 8'(overflow), 8'h01);
    chk_status("post flush", 0);
    step(0, 0, 8'h00, 0, 0, 0);
    chk("ovf cleared by reset", 8'(overflow), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
